// File: rtl/systolic_skew_feeder.sv
// Systolic skew feeder: pops ARRAY_SIZE-element vectors from the input FIFO
// and presents them to the array edge with diagonal skew (lane i delayed i
// cycles after lane 0). It feeds k_len vectors, flushes the skew pipeline,
// then pulses done.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, k_len    begin a pass of k_len vectors (sampled only in IDLE)
//   stall           array back-pressure; freezes the whole block
//   in_data/valid   FIFO head; in_ready is the pop strobe
//   skew_data/valid skewed lane outputs, same packing as in_data
//   busy, done      pass in progress / one-cycle end-of-pass pulse
//   bubble_cnt      (SKEW_BUBBLE_CNT_EN only) unstalled FEED cycles with no
//                   vector available, saturating
//
// Optional feature macro: SKEW_BUBBLE_CNT_EN
module systolic_skew_feeder #(
  parameter int unsigned ARRAY_SIZE = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [LEN_WIDTH-1:0]             k_len,
  input  logic                             stall,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] skew_data,
  output logic [ARRAY_SIZE-1:0]            skew_valid,
  output logic                             busy,
`ifdef SKEW_BUBBLE_CNT_EN
  output logic [31:0]                      bubble_cnt,
`endif
  output logic                             done
);

  localparam int unsigned FLUSH_LAST = (ARRAY_SIZE > 1) ? ARRAY_SIZE - 2 : 0;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] k_len_q;
  logic [LEN_WIDTH-1:0] vec_cnt;
  logic [LEN_WIDTH-1:0] flush_cnt;
  logic                 accept;

  // Pop strobe is only offered in FEED and is withdrawn under stall.
  assign in_ready = (state == FEED) && !stall;
  assign accept   = in_ready && in_valid;

  // Control FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_len_q   <= '0;
      vec_cnt   <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (!stall) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (k_len != '0) begin
              k_len_q <= k_len;
              vec_cnt <= '0;
              state   <= FEED;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        FEED: begin
          if (accept) begin
            vec_cnt <= vec_cnt + LEN_WIDTH'(1);
            if (vec_cnt == k_len_q - LEN_WIDTH'(1)) begin
              flush_cnt <= '0;
              // A single lane has no skew to flush.
              if (ARRAY_SIZE == 1) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == LEN_WIDTH'(FLUSH_LAST)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + LEN_WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-lane delay lines: lane i has i+1 stages; its last stage is the output.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] d_q [i+1];
    logic                  v_q [i+1];

    // Stage 0 captures the accepted element, or a bubble.
    always_ff @(posedge clk) begin
      if (rst) begin
        d_q[0] <= '0;
        v_q[0] <= 1'b0;
      end else if (!stall) begin
        d_q[0] <= accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        v_q[0] <= accept;
      end
    end

    for (genvar j = 1; j <= i; j++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q[j] <= '0;
          v_q[j] <= 1'b0;
        end else if (!stall) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
        end
      end
    end

    assign skew_data[i*DATA_WIDTH +: DATA_WIDTH] = d_q[i];
    assign skew_valid[i]                         = v_q[i];
  end

`ifdef SKEW_BUBBLE_CNT_EN
  // Counts FEED cycles starved by an empty FIFO; cleared on accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!stall) begin
      if (state == IDLE && start) begin
        bubble_cnt <= '0;
      end else if (state == FEED && !in_valid && bubble_cnt != 32'hFFFF_FFFF) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (ARRAY_SIZE=4). Expected lane
// elements are queued per lane when a vector is driven and popped by a
// monitor whenever the lane shows a valid element.
module tb_systolic_skew_feeder;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [LW-1:0]   k_len = '0;
  logic            stall = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] skew_data;
  logic [N-1:0]    skew_valid;
  logic            busy;
  logic            done;
`ifdef SKEW_BUBBLE_CNT_EN
  logic [31:0]     bubble_cnt;
`endif

  systolic_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .skew_data(skew_data), .skew_valid(skew_valid), .busy(busy),
`ifdef SKEW_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ue;
    logic [DW-1:0] d;
  } exp_t;

  exp_t lane_q [N][$];

  int checks = 0;
  int passed = 0;
  int edge_n = 0;     // all rising edges
  int ue_n = 0;       // unstalled rising edges
  int pops = 0;
  int done_cnt = 0;
  logic last_stalled = 1'b0;
  logic done_prev = 1'b0;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (!stall) ue_n = ue_n + 1;
    last_stalled = stall;
    if (in_valid && in_ready) pops = pops + 1;
  end

  // Scoreboard monitor: every valid lane element must match the queue head,
  // both in value and in the unstalled edge at which it is due.
  always @(negedge clk) begin
    if (!last_stalled) begin
      for (int i = 0; i < N; i++) begin
        if (skew_valid[i] === 1'b1) begin
          checks++;
          if (lane_q[i].size() == 0) begin
            $display("FAIL lane%0d_unexpected: got data %h at ue %0d, required no valid",
                     i, skew_data[i*DW +: DW], ue_n);
          end else begin
            exp_t e;
            e = lane_q[i].pop_front();
            if (e.d !== skew_data[i*DW +: DW] || e.ue != ue_n)
              $display("FAIL lane%0d_data: got %h at ue %0d, required %h at ue %0d",
                       i, skew_data[i*DW +: DW], ue_n, e.d, e.ue);
            else passed++;
          end
        end
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_cnt++;
    done_prev = done;
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Queue a vector that the next edge is expected to accept.
  task automatic push_vec(input logic [N*DW-1:0] v);
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.ue = ue_n + 1 + i;
      e.d  = v[i*DW +: DW];
      lane_q[i].push_back(e);
    end
  endtask

  task automatic wait_done(output int e);
    e = -1;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) begin
        e = edge_n;
        break;
      end
      cycle();
    end
  endtask

  task automatic do_start(input logic [LW-1:0] n);
    start = 1'b1;
    k_len = n;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [N*DW-1:0] v;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    checks++;
    if ({skew_data, skew_valid, busy, done, in_ready} !== '0)
      $display("FAIL reset_outputs: got %h/%b busy %b done %b rdy %b, required all 0",
               skew_data, skew_valid, busy, done, in_ready);
    else passed++;
    // Abort mid-FEED: two vectors accepted, then reset held for two edges.
    do_start(LW'(5));
    for (int k = 0; k < 2; k++) begin
      v = {$urandom, $urandom};
      in_data = v;
      in_valid = 1'b1;
      push_vec(v);
      cycle();
    end
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    checks++;
    if ({skew_data, skew_valid, busy, done, in_ready} !== '0)
      $display("FAIL midpass_reset: got %h/%b busy %b done %b rdy %b, required all 0",
               skew_data, skew_valid, busy, done, in_ready);
    else passed++;
`ifdef SKEW_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 32'd0) $display("FAIL reset_bubble_cnt: got %0d, required 0", bubble_cnt);
    else passed++;
`endif
    pops = 0;
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
        $display("FAIL post_reset_idle: got rdy %b done %b busy %b, required 0 0 0",
                 in_ready, done, busy);
      else passed++;
    end
    in_valid = 1'b0;
    checks++;
    if (pops != 0 || done_cnt != 0)
      $display("FAIL post_reset_pops: got pops %0d dones %0d, required 0 0", pops, done_cnt);
    else passed++;
  endtask

  task automatic test_single();
    int acc;
    int de;
    do_start(LW'(1));
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL feed_ready: got rdy %b busy %b, required 1 1", in_ready, busy);
    else passed++;
    in_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    in_valid = 1'b1;
    push_vec(in_data);
    acc = edge_n + 1;
    cycle();
    in_valid = 1'b0;
    wait_done(de);
    checks++;
    if (de != acc + 3) $display("FAIL single_done_edge: got %0d, required %0d", de, acc + 3);
    else passed++;
    checks++;
    if (skew_valid !== 4'b1000 || skew_data[3*DW +: DW] !== 16'h0004)
      $display("FAIL single_done_lane3: got valid %b data %h, required 1000 0004",
               skew_valid, skew_data[3*DW +: DW]);
    else passed++;
    cycle();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL single_after_done: got busy %b done %b, required 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_gaps();
    int last_acc;
    int de;
    logic [N*DW-1:0] v;
    pops = 0;
    do_start(LW'(3));
    for (int p = 0; p < 5; p++) begin
      in_valid = (p % 2 == 0);
      v = {$urandom, $urandom};
      in_data = v;
      if (in_valid) push_vec(v);
      cycle();
      if (p % 2 == 0) last_acc = edge_n;
    end
    in_valid = 1'b0;
    wait_done(de);
    checks++;
    if (de != last_acc + 3) $display("FAIL gaps_done_edge: got %0d, required %0d", de, last_acc + 3);
    else passed++;
    checks++;
    if (pops != 3) $display("FAIL gaps_pops: got %0d, required 3", pops);
    else passed++;
`ifdef SKEW_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 32'd2) $display("FAIL gaps_bubble_cnt: got %0d, required 2", bubble_cnt);
    else passed++;
`endif
    cycle();
  endtask

  task automatic test_stall_flush();
    int last_acc;
    int de;
    logic [N*DW-1:0] v;
    logic [N*DW-1:0] sd;
    logic [N-1:0]    sv;
    do_start(LW'(2));
    for (int k = 0; k < 2; k++) begin
      v = {$urandom, $urandom};
      in_data = v;
      in_valid = 1'b1;
      push_vec(v);
      cycle();
    end
    last_acc = edge_n;
    in_valid = 1'b0;
    cycle();
    sd = skew_data;
    sv = skew_valid;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (skew_data !== sd || skew_valid !== sv || in_ready !== 1'b0)
        $display("FAIL stall_frozen: got %h/%b rdy %b, required %h/%b rdy 0",
                 skew_data, skew_valid, in_ready, sd, sv);
      else passed++;
    end
    stall = 1'b0;
    wait_done(de);
    checks++;
    if (de != last_acc + 6) $display("FAIL stall_done_edge: got %0d, required %0d", de, last_acc + 6);
    else passed++;
    cycle();
  endtask

  task automatic test_zero_len();
    pops = 0;
    in_data = {$urandom, $urandom};
    in_valid = 1'b1;
    do_start(LW'(0));
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL zero_done: got done %b busy %b rdy %b, required 1 1 0", done, busy, in_ready);
    else passed++;
    cycle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_after: got done %b busy %b, required 0 0", done, busy);
    else passed++;
    cycle();
    cycle();
    in_valid = 1'b0;
    checks++;
    if (pops != 0) $display("FAIL zero_pops: got %0d, required 0", pops);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int de;
    int last_acc;
    logic [N*DW-1:0] v;
    pops = 0;
    done_cnt = 0;
    do_start(LW'(2));
    for (int k = 0; k < 2; k++) begin
      v = {$urandom, $urandom};
      in_data = v;
      in_valid = 1'b1;
      push_vec(v);
      if (k == 1) begin
        start = 1'b1;
        k_len = LW'(5);
      end
      cycle();
    end
    last_acc = edge_n;
    start = 1'b0;
    in_data = {$urandom, $urandom};
    wait_done(de);
    checks++;
    if (de != last_acc + 3) $display("FAIL restart_done_edge: got %0d, required %0d", de, last_acc + 3);
    else passed++;
    for (int k = 0; k < 4; k++) cycle();
    in_valid = 1'b0;
    checks++;
    if (pops != 2 || done_cnt != 1)
      $display("FAIL restart_counts: got pops %0d dones %0d, required 2 1", pops, done_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_stall_flush();
    test_zero_len();
    test_back_to_back();
    cycle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lane_q[i].size() != 0)
        $display("FAIL lane%0d_drained: got %0d pending, required 0", i, lane_q[i].size());
      else passed++;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
